// File: rtl/dseq_pkg.sv
// dseq_pkg: instruction layout, FSM states and instruction struct for datapath_sequencer
package dseq_pkg;
    localparam int OP_W = 3;
    localparam int REG_AW = 2;
    localparam int INSTR_W = 9;
    typedef enum logic [1:0] {IDLE, ISSUE, WRITE} state_t;
    typedef struct packed {
        logic [OP_W-1:0] op;
        logic [REG_AW-1:0] rd;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
    } instr_t;
endpackage

// File: rtl/datapath_sequencer_if.sv
// datapath_sequencer_if: instruction handshake plus datapath control bus
// Optional result capture ports appear when DSEQ_RESULT_OUT_EN is defined.
interface datapath_sequencer_if import dseq_pkg::*; #(parameter int CNT_W = 16);
    logic in_valid;
    logic [INSTR_W-1:0] in_instr;
    logic in_ready;
    logic [OP_W-1:0] alucontrol;
    logic [REG_AW-1:0] addr1;
    logic [REG_AW-1:0] addr2;
    logic [REG_AW-1:0] addr3;
    logic wr;
    logic busy;
    logic done;
    logic [CNT_W-1:0] retired;
`ifdef DSEQ_RESULT_OUT_EN
    logic [31:0] result_in;
    logic [31:0] rsp_data;
`endif
    modport master (
        output in_valid, in_instr,
`ifdef DSEQ_RESULT_OUT_EN
        output result_in,
        input rsp_data,
`endif
        input in_ready, alucontrol, addr1, addr2, addr3, wr, busy, done, retired
    );
    modport slave (
        input in_valid, in_instr,
`ifdef DSEQ_RESULT_OUT_EN
        input result_in,
        output rsp_data,
`endif
        output in_ready, alucontrol, addr1, addr2, addr3, wr, busy, done, retired
    );
endinterface

// File: rtl/dseq_fifo.sv
// dseq_fifo: synchronous FIFO, wrap-around pointers with an extra MSB for full/empty
module dseq_fifo #(
    parameter int DEPTH = 4,
    parameter int W = 9
) (
    input logic clk,
    input logic rst,
    input logic push,
    input logic pop,
    input logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic full,
    output logic empty
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0] mem [DEPTH];
    logic [AW:0] wp, rp;
    always_ff @(posedge clk) begin
        if (rst) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (push && !full) wp <= wp + 1'b1;
            if (pop && !empty) rp <= rp + 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (push && !full) mem[wp[AW-1:0]] <= wdata;
    end
    assign rdata = mem[rp[AW-1:0]];
    assign empty = wp == rp;
    assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
endmodule

// File: rtl/datapath_sequencer.sv
// datapath_sequencer: queues 9-bit instructions and issues each as an ISSUE/WRITE pair
// Define DSEQ_RESULT_OUT_EN to add result_in capture into rsp_data.
module datapath_sequencer import dseq_pkg::*; #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input logic clk,
    input logic rst,
    datapath_sequencer_if.slave bus
);
    state_t state, nxt;
    instr_t head, ir, cur;
    logic full, empty, push, pop, done;
    logic [CNT_W-1:0] retired;
    assign push = bus.in_valid && !full;
    assign pop = state == ISSUE;
    dseq_fifo #(.DEPTH(DEPTH), .W(INSTR_W)) u_fifo (
        .clk(clk),
        .rst(rst),
        .push(push),
        .pop(pop),
        .wdata(bus.in_instr),
        .rdata(head),
        .full(full),
        .empty(empty)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ir <= '0;
            done <= 1'b0;
            retired <= '0;
        end else begin
            state <= nxt;
            done <= state == WRITE;
            if (state == ISSUE) ir <= head;
            if (state == WRITE) retired <= retired + 1'b1;
        end
    end
    // WRITE re-enters ISSUE if this cycle's push leaves the FIFO non-empty
    always_comb begin
        nxt = IDLE;
        nxt = (state == IDLE) ? (empty ? IDLE : ISSUE) :
              (state == ISSUE) ? WRITE :
              (!empty || push) ? ISSUE : IDLE;
        cur = (state == ISSUE) ? head : ir;
        bus.wr = (state == WRITE) && !rst;
        bus.busy = !empty || (state != IDLE);
    end
    assign bus.in_ready = !full;
    assign bus.alucontrol = cur.op;
    assign bus.addr1 = cur.rs1;
    assign bus.addr2 = cur.rs2;
    assign bus.addr3 = cur.rd;
    assign bus.done = done;
    assign bus.retired = retired;
`ifdef DSEQ_RESULT_OUT_EN
    logic [31:0] rsp_data;
    always_ff @(posedge clk) begin
        if (rst) rsp_data <= '0;
        else if (state == WRITE) rsp_data <= bus.result_in;
    end
    assign bus.rsp_data = rsp_data;
`endif
endmodule

// File: tb/tb_datapath_sequencer.sv
// tb_datapath_sequencer: directed self-checking bench for datapath_sequencer (DEPTH=4, CNT_W=4)
module tb_datapath_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int failures = 0;
    datapath_sequencer_if #(.CNT_W(4)) bus();
    datapath_sequencer #(.DEPTH(4), .CNT_W(4)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );
    always #5 clk = ~clk;
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    function automatic logic [8:0] fields();
        return {bus.alucontrol, bus.addr3, bus.addr1, bus.addr2};
    endfunction
    initial begin : main
        logic [8:0] fill [7];
        logic [15:0] er, ew;
        logic acc;
        int pi, widx, k;
        fill[0] = 9'b001_00_01_10;
        fill[1] = 9'b011_01_10_11;
        fill[2] = 9'b100_10_11_00;
        fill[3] = 9'b101_11_00_01;
        fill[4] = 9'b111_01_01_01;
        fill[5] = 9'b000_10_10_11;
        fill[6] = 9'b010_11_10_01;
        er = 16'b1111_1110_1011_1111;
        ew = 16'b1010_1010_1010_1000;
        bus.in_valid = 1'b0;
        bus.in_instr = '0;
`ifdef DSEQ_RESULT_OUT_EN
        bus.result_in = '0;
`endif
        tick;
        tick;
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_alu", bus.alucontrol, 0);
        check("rst_addrs", {bus.addr1, bus.addr2, bus.addr3}, 0);
        check("rst_wr", bus.wr, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_retired", bus.retired, 0);
`ifdef DSEQ_RESULT_OUT_EN
        check("rst_rsp", bus.rsp_data, 0);
`endif
        rst = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_instr = 9'b010_11_01_10;
        tick;
        bus.in_valid = 1'b0;
        check("single_idle_busy", bus.busy, 1);
        check("single_idle_wr", bus.wr, 0);
        tick;
        check("single_issue_addr1", bus.addr1, 1);
        check("single_issue_addr2", bus.addr2, 2);
        check("single_issue_addr3", bus.addr3, 3);
        check("single_issue_alu", bus.alucontrol, 2);
        check("single_issue_wr", bus.wr, 0);
`ifdef DSEQ_RESULT_OUT_EN
        bus.result_in = 32'hDEADBEEF;
`endif
        tick;
        check("single_write_wr", bus.wr, 1);
        check("single_write_fields", fields(), 9'b010_11_01_10);
        tick;
`ifdef DSEQ_RESULT_OUT_EN
        bus.result_in = 32'h12345678;
        check("single_rsp_done", bus.rsp_data, 32'hDEADBEEF);
`endif
        check("single_done", bus.done, 1);
        check("single_retired", bus.retired, 1);
        check("single_after_wr", bus.wr, 0);
        check("single_after_busy", bus.busy, 0);
        tick;
        check("single_done_pulse", bus.done, 0);
        check("single_hold_fields", fields(), 9'b010_11_01_10);
`ifdef DSEQ_RESULT_OUT_EN
        check("single_rsp_hold", bus.rsp_data, 32'hDEADBEEF);
`endif
        pi = 0;
        widx = 0;
        for (int n = 0; n < 16; n++) begin
            bus.in_valid = pi < 7;
            bus.in_instr = (pi < 7) ? fill[pi] : 9'd0;
            check($sformatf("fill_ready_%0d", n), bus.in_ready, er[n]);
            check($sformatf("fill_wr_%0d", n), bus.wr, ew[n]);
            if (bus.wr && widx < 7) begin
                check($sformatf("fill_order_%0d", widx), fields(), fill[widx]);
                widx++;
            end
            acc = bus.in_valid && bus.in_ready;
            tick;
            if (acc) pi++;
        end
        bus.in_valid = 1'b0;
        check("fill_accepted", pi, 7);
        check("fill_written", widx, 7);
        check("fill_done", bus.done, 1);
        check("fill_retired", bus.retired, 8);
        check("fill_idle_busy", bus.busy, 0);
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1;
            bus.in_instr = fill[i];
            tick;
        end
        bus.in_valid = 1'b0;
        check("rstw_pre_wr", bus.wr, 1);
        rst = 1'b1;
        #1;
        check("rstw_wr_gated", bus.wr, 0);
        check("rstw_retired_hold", bus.retired, 8);
        tick;
        rst = 1'b0;
        check("rstw_busy", bus.busy, 0);
        check("rstw_in_ready", bus.in_ready, 1);
        check("rstw_retired", bus.retired, 0);
        check("rstw_done", bus.done, 0);
        for (int i = 0; i < 6; i++) begin
            tick;
            check($sformatf("rstw_no_wr_%0d", i), bus.wr | bus.busy | bus.done, 0);
        end
        check("rstw_retired_final", bus.retired, 0);
        for (int i = 0; i < 17; i++) begin
            bus.in_valid = 1'b1;
            bus.in_instr = 9'(i * 37);
            k = 0;
            while (!bus.in_ready && k < 50) begin
                tick;
                k++;
            end
            check("wrap_push_timeout", k < 50, 1);
            tick;
        end
        bus.in_valid = 1'b0;
        k = 0;
        while (bus.busy && k < 200) begin
            tick;
            k++;
        end
        check("wrap_drain_timeout", k < 200, 1);
        check("wrap_done", bus.done, 1);
        check("wrap_retired", bus.retired, 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
